// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional `ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP with illegal_o set.
module multicycle_controller #(
    parameter int MAX_WAIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       mem_ready,
    input  logic       BrTaken,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [3:0] state_o,
    output logic       instr_done,
    output logic       mem_err,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        JALR   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wait_st, timeout;

    assign wait_st = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    // mem_ready in the last allowed cycle beats the timeout
    assign timeout = (MAX_WAIT > 0) && wait_st && !mem_ready && (cnt_q == LAST);
    assign cnt_d   = (wait_st && !mem_ready && !timeout) ? cnt_q + CW'(1) : '0;
    assign state_o = state_q;

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        ResultSrc  = 2'b00;
        instr_done = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (timeout) begin
                    mem_err = 1'b1;
                end else begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC_R;
                    OP_I:         state_d = EXEC_I;
                    OP_BR:        state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    OP_JALR:      state_d = JALR;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        instr_done = 1'b1;
                        state_d    = FETCH;
`endif
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (Opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (timeout) begin
                    mem_err = 1'b1;
                    state_d = FETCH;
                end else begin
                    MemRead = 1'b1;
                    if (mem_ready) state_d = MEMWB;
                end
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                ResultSrc  = 2'b01;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                if (timeout) begin
                    mem_err = 1'b1;
                    state_d = FETCH;
                end else begin
                    MemWrite = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            EXEC_R: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            EXEC_I: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                PCWrite    = BrTaken;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = JAL;
            end
            JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP:    state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase
        // nothing may strobe while reset is held, even combinationally
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUOp      = 2'b00;
            ResultSrc  = 2'b00;
            instr_done = 1'b0;
            mem_err    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_q | (state_d == TRAP);
    end

    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

endmodule
